// File: rtl/credit_bank_if.sv
// Credit bank control/status bundle: the arbiter side drives grants, bids and
// overrides; the bank returns balances and status flags.
interface credit_bank_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned BAL_W = 10,
    parameter int unsigned BID_W = 4
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                    en;
    logic [N_CH-1:0]         grant;
    logic [N_CH*BID_W-1:0]   bid;
    logic                    refill_mode;
    logic                    ld_valid;
    logic [CH_W-1:0]         ld_ch;
    logic [BAL_W-1:0]        ld_val;
    logic [N_CH*BAL_W-1:0]   balance;
    logic [N_CH-1:0]         exhausted;
    logic                    refill_tick;

    modport master (
        output en, grant, bid, refill_mode, ld_valid, ld_ch, ld_val,
        input  balance, exhausted, refill_tick
    );

    modport slave (
        input  en, grant, bid, refill_mode, ld_valid, ld_ch, ld_val,
        output balance, exhausted, refill_tick
    );
endinterface

// File: rtl/credit_bank.sv
// Per-requester credit tracker for the weighted round-robin arbiter: debits on
// grant, periodic replenish, software override, floor/exhausted flagging.
module credit_bank #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned BAL_W    = 10,
    parameter int unsigned BID_W    = 4,
    parameter int unsigned INIT_BAL = 750,
    parameter int unsigned REFILL   = 750,
    parameter int unsigned CAP      = 900,
    parameter int unsigned FLOOR    = 1,
    parameter int unsigned PERIOD   = 401
) (
    input  logic           clk,
    input  logic           rst,
    credit_bank_if.slave   bus
);
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CNT_W = $clog2(PERIOD);
    localparam int unsigned EXT_W = BAL_W + 1;

    localparam logic [EXT_W-1:0] FLOOR_X  = EXT_W'(FLOOR);
    localparam logic [EXT_W-1:0] CAP_X    = EXT_W'(CAP);
    localparam logic [EXT_W-1:0] INIT_X   = EXT_W'(INIT_BAL);
    localparam logic [EXT_W-1:0] REFILL_X = EXT_W'(REFILL);
    localparam logic [BAL_W-1:0] INIT_B   = BAL_W'(INIT_BAL);
    localparam logic [BAL_W-1:0] FLOOR_B  = BAL_W'(FLOOR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_c;
    logic [EXT_W-1:0] ld_ext_c;
    logic [EXT_W-1:0] ld_clamp_c;

    assign tick_c          = bus.en & (cnt_q == CNT_LAST);
    assign bus.refill_tick = tick_c;

    // Replenish period counter, frozen while disabled
    always_comb begin
        cnt_d = cnt_q;
        if (bus.en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Override value clamped into the legal balance range
    assign ld_ext_c = {1'b0, bus.ld_val};
    always_comb begin
        ld_clamp_c = ld_ext_c;
        if (ld_ext_c < FLOOR_X) begin
            ld_clamp_c = FLOOR_X;
        end else if (ld_ext_c > CAP_X) begin
            ld_clamp_c = CAP_X;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [BAL_W-1:0] bal_q;
        logic [BAL_W-1:0] bal_d;
        logic [EXT_W-1:0] bal_x;
        logic [EXT_W-1:0] bid_x;
        logic [EXT_W-1:0] deb_x;
        logic [EXT_W-1:0] sum_x;
        logic [EXT_W-1:0] ref_x;

        assign bal_x = {1'b0, bal_q};
        assign bid_x = EXT_W'(bus.bid[i*BID_W +: BID_W]);

        // Debit first, then refill on the same edge so no credit is lost
        always_comb begin
            deb_x = bal_x;
            if (bus.grant[i]) begin
                deb_x = (bal_x >= bid_x + FLOOR_X) ? bal_x - bid_x : FLOOR_X;
            end
            sum_x = deb_x + REFILL_X;
            ref_x = bus.refill_mode ? INIT_X : ((sum_x > CAP_X) ? CAP_X : sum_x);

            bal_d = bal_q;
            if (bus.ld_valid && (bus.ld_ch == CH_W'(i))) begin
                bal_d = BAL_W'(ld_clamp_c);
            end else if (bus.en) begin
                bal_d = tick_c ? BAL_W'(ref_x) : BAL_W'(deb_x);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                bal_q <= INIT_B;
            end else begin
                bal_q <= bal_d;
            end
        end

        assign bus.balance[i*BAL_W +: BAL_W] = bal_q;
        assign bus.exhausted[i]              = (bal_q == FLOOR_B);
    end
endmodule

// File: tb/tb_credit_bank.sv
// Scoreboarded bench for credit_bank: the driver advances an arithmetic model
// and queues the expected post-edge state; a monitor compares every cycle.
module tb_credit_bank;
    localparam int N_CH     = 4;
    localparam int BAL_W    = 10;
    localparam int BID_W    = 4;
    localparam int INIT_BAL = 750;
    localparam int REFILL   = 750;
    localparam int CAP      = 900;
    localparam int FLOOR    = 1;
    localparam int PERIOD   = 401;

    typedef struct packed {
        logic [N_CH*BAL_W-1:0] bal;
        logic [N_CH-1:0]       exh;
        logic                  tick;
    } exp_t;

    logic clk;
    logic rst;

    credit_bank_if #(.N_CH(N_CH), .BAL_W(BAL_W), .BID_W(BID_W)) bus ();

    credit_bank #(
        .N_CH(N_CH), .BAL_W(BAL_W), .BID_W(BID_W), .INIT_BAL(INIT_BAL),
        .REFILL(REFILL), .CAP(CAP), .FLOOR(FLOOR), .PERIOD(PERIOD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t mon_x;
    int   m_bal[N_CH];
    int   m_cnt;

    function automatic int clampv(input int v);
        if (v < FLOOR) return FLOOR;
        if (v > CAP) return CAP;
        return v;
    endfunction

    function automatic int bal_of(input int ch);
        logic [N_CH*BAL_W-1:0] v;
        v = bus.balance;
        return int'(v[ch*BAL_W +: BAL_W]);
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // One clock: drive at the falling edge, advance the model, queue expectation
    task automatic step(input logic r, input logic e, input logic [N_CH-1:0] g,
                        input logic [N_CH*BID_W-1:0] b, input logic m,
                        input logic lv, input logic [1:0] lc, input logic [BAL_W-1:0] lval);
        exp_t x;
        int   d;
        int   bd;
        bit   tk;
        @(negedge clk);
        rst             = r;
        bus.en          = e;
        bus.grant       = g;
        bus.bid         = b;
        bus.refill_mode = m;
        bus.ld_valid    = lv;
        bus.ld_ch       = lc;
        bus.ld_val      = lval;
        if (!r) begin
            for (int i = 0; i < N_CH; i++) m_bal[i] = INIT_BAL;
            m_cnt = 0;
        end else begin
            tk = e && (m_cnt == PERIOD - 1);
            for (int i = 0; i < N_CH; i++) begin
                bd = int'(b[i*BID_W +: BID_W]);
                if (lv && int'(lc) == i) begin
                    m_bal[i] = clampv(int'(lval));
                end else if (e) begin
                    d = m_bal[i];
                    if (g[i]) d = (d - bd >= FLOOR) ? d - bd : FLOOR;
                    if (tk) d = m ? INIT_BAL : ((d + REFILL > CAP) ? CAP : d + REFILL);
                    m_bal[i] = d;
                end
            end
            if (e) m_cnt = (m_cnt + 1) % PERIOD;
        end
        for (int i = 0; i < N_CH; i++) begin
            x.bal[i*BAL_W +: BAL_W] = BAL_W'(m_bal[i]);
            x.exh[i]                = (m_bal[i] == FLOOR);
        end
        x.tick = r && e && (m_cnt == PERIOD - 1);
        exp_q.push_back(x);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, '0, '0, 1'b0, 1'b0, 2'd0, '0);
    endtask

    task automatic ld(input logic [1:0] ch, input logic [BAL_W-1:0] v);
        step(1'b1, 1'b1, '0, '0, 1'b0, 1'b1, ch, v);
    endtask

    task automatic idle_until(input int target);
        int k;
        k = 0;
        while (m_cnt != target && k < 1000) begin
            idle();
            k++;
        end
        if (m_cnt != target) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_until: counter at %0d, expected %0d", m_cnt, target);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every post-edge sample is checked against the queued expectation
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_x = exp_q.pop_front();
            n_tests++;
            if (bus.balance !== mon_x.bal) begin
                n_fail++;
                $display("FAIL balance: got %h, expected %h", bus.balance, mon_x.bal);
            end
            n_tests++;
            if (bus.exhausted !== mon_x.exh) begin
                n_fail++;
                $display("FAIL exhausted: got %b, expected %b", bus.exhausted, mon_x.exh);
            end
            n_tests++;
            if (bus.refill_tick !== mon_x.tick) begin
                n_fail++;
                $display("FAIL refill_tick: got %b, expected %b", bus.refill_tick, mon_x.tick);
            end
        end
    end

    initial begin
        int saved[N_CH];
        int ticks;
        int k;
        logic [BAL_W-1:0] lv_val;

        rst             = 1'b0;
        bus.en          = 1'b0;
        bus.grant       = '0;
        bus.bid         = '0;
        bus.refill_mode = 1'b0;
        bus.ld_valid    = 1'b0;
        bus.ld_ch       = '0;
        bus.ld_val      = '0;
        for (int i = 0; i < N_CH; i++) m_bal[i] = INIT_BAL;
        m_cnt = 0;

        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 2'd0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 2'd0, '0);
        settle();
        chk("reset_bal0", bal_of(0), 750);
        chk("reset_exh", int'(bus.exhausted), 0);

        // Debit: three grants of 5 on channel 0
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 4'b0001, 16'h0005, 1'b0, 1'b0, 2'd0, '0);
        settle();
        chk("t2_ch0", bal_of(0), 735);
        chk("t2_ch1", bal_of(1), 750);

        // Floor
        ld(2'd1, 10'd3);
        step(1'b1, 1'b1, 4'b0010, 16'h0070, 1'b0, 1'b0, 2'd0, '0);
        settle();
        chk("t3_floor", bal_of(1), 1);
        chk("t3_exh", int'(bus.exhausted[1]), 1);
        step(1'b1, 1'b1, 4'b0010, 16'h0010, 1'b0, 1'b0, 2'd0, '0);
        settle();
        chk("t3_hold", bal_of(1), 1);

        // Mode-0 refill with cap
        idle_until(PERIOD - 3);
        ld(2'd2, 10'd100);
        ld(2'd3, 10'd200);
        idle();
        settle();
        chk("t4_ch2", bal_of(2), 850);
        chk("t4_ch3", bal_of(3), 900);

        ticks = 0;
        for (int n = 0; n < PERIOD; n++) begin
            idle();
            #1;
            if (bus.refill_tick) ticks++;
        end
        chk("t4_tick_count", ticks, 1);

        // Grant and refill on the same edge
        idle_until(PERIOD - 3);
        ld(2'd0, 10'd500);
        ld(2'd1, 10'd100);
        step(1'b1, 1'b1, 4'b0011, 16'h00AA, 1'b0, 1'b0, 2'd0, '0);
        settle();
        chk("t5_cap", bal_of(0), 900);
        chk("t5_sum", bal_of(1), 840);
        idle_until(PERIOD - 1);
        step(1'b1, 1'b1, 4'b1111, 16'hFFFF, 1'b1, 1'b0, 2'd0, '0);
        settle();
        chk("t5_mode1", bal_of(0), 750);

        // Disabled: grants ignored, balances frozen
        for (int i = 0; i < N_CH; i++) saved[i] = m_bal[i];
        for (int n = 0; n < 50; n++)
            step(1'b1, 1'b0, 4'($urandom), 16'($urandom), 1'($urandom), 1'b0, 2'd0, '0);
        settle();
        chk("t6_frozen0", bal_of(0), saved[0]);
        chk("t6_frozen3", bal_of(3), saved[3]);
        ld(2'd0, 10'd1000);
        settle();
        chk("t6_ld_clamp", bal_of(0), 900);
        step(1'b1, 1'b1, 4'b0001, 16'h0005, 1'b0, 1'b1, 2'd0, 10'd20);
        settle();
        chk("t6_ld_wins", bal_of(0), 20);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 2'd2, 10'd0);
        settle();
        chk("t6_ld_en0", bal_of(2), 1);

        // Asynchronous reset mid-run
        step(1'b0, 1'b1, 4'b1111, 16'h3333, 1'b0, 1'b0, 2'd0, '0);
        #1;
        chk("t1_async_bal", (bus.balance == {N_CH{10'd750}}) ? 1 : 0, 1);
        chk("t1_async_tick", int'(bus.refill_tick), 0);
        chk("t1_async_exh", int'(bus.exhausted), 0);
        step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 2'd0, '0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            k = int'($urandom_range(0, 3));
            lv_val = (k == 0) ? 10'(FLOOR - 1) : ((k == 1) ? 10'($urandom_range(1, 20)) : 10'($urandom));
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) != 0),
                 4'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), 2'($urandom), lv_val);
        end
        idle();

        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        #3;
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
